md_ctrl: RTL

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl_pkg.sv | 71 +++++++
 rtl/md_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/md_ctrl_pkg.sv
// md_ctrl_pkg: shared constants and helpers for the HI/LO multiply-divide unit.
//   MD_* op codes      : md_op encodings shared with the control and stall units
//   MD_MUL_LAT/DIV_LAT : busy-period length in cycles for multiply / divide
//   md_state_e         : IDLE/BUSY state of the md_ctrl FSM
//   md_arith()         : computes the {HI, LO} result of a multiply/divide op
package md_ctrl_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [3:0] MD_MUL_LAT = 4'd5;
  localparam logic [3:0] MD_DIV_LAT = 4'd10;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } md_state_e;

  // Returns {HI, LO}. A zero divisor returns hilo_cur so HI/LO stay unchanged.
  // Signed divide works on magnitudes, then restores signs: quotient truncates
  // toward zero, remainder takes the dividend's sign. This also yields
  // 0x80000000 / -1 = 0x80000000 rem 0 without overflow.
  function automatic logic [63:0] md_arith(input logic [2:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [63:0] hilo_cur);
    logic [63:0] ax;
    logic [63:0] bx;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    md_arith = hilo_cur;
    ax = {32'b0, a};
    bx = {32'b0, b};
    ma = a;
    mb = b;
    q  = '0;
    r  = '0;
    case (op)
      MD_MULT: begin
        ax = {{32{a[31]}}, a};
        bx = {{32{b[31]}}, b};
        md_arith = ax * bx;
      end
      MD_MULTU: begin
        md_arith = ax * bx;
      end
      MD_DIV: begin
        if (b != '0) begin
          ma = a[31] ? -a : a;
          mb = b[31] ? -b : b;
          q  = ma / mb;
          r  = ma % mb;
          if (a[31] ^ b[31]) q = -q;
          if (a[31]) r = -r;
          md_arith = {r, q};
        end
      end
      MD_DIVU: begin
        if (b != '0) md_arith = {a % b, a / b};
      end
      default: ;
    endcase
  endfunction

endpackage

// File: rtl/md_ctrl.sv
// md_ctrl: HI/LO multiply-divide controller.
// Computes MULT/MULTU/DIV/DIVU at issue into shadow registers, then holds a
// fixed busy period before committing to the architectural HI/LO. MTHI/MTLO
// write HI/LO directly at the next edge.
// Ports:
//   clk        : clock, rising edge
//   reset_n    : synchronous active-low reset
//   start      : one-cycle issue strobe
//   md_op[2:0] : operation code (MD_* in md_ctrl_pkg)
//   rs_val     : dividend / multiplicand / MT data
//   rt_val     : divisor / multiplier
//   rd_sel     : 1 reads HI, 0 reads LO on rdata
//   rdata      : current HI or LO value
//   hilo_busy  : start OR busy, for the HILO stall interlock
//   hi, lo     : architectural HI/LO values
module md_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_sel,
  output logic [31:0] rdata,
  output logic        hilo_busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  import md_ctrl_pkg::*;

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_n_q, hi_n_d;
  logic [31:0] lo_n_q, lo_n_d;
  logic        busy_q;

  assign busy_q = (state_q == S_BUSY);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_n_q  <= '0;
      lo_n_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
    end
  end

  // Next-state logic; any start seen while BUSY is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              {hi_n_d, lo_n_d} = md_arith(md_op, rs_val, rt_val, {hi_q, lo_q});
              cnt_d   = MD_MUL_LAT;
              state_d = S_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              {hi_n_d, lo_n_d} = md_arith(md_op, rs_val, rt_val, {hi_q, lo_q});
              cnt_d   = MD_DIV_LAT;
              state_d = S_BUSY;
            end
            MD_MTHI: hi_d = rs_val;
            MD_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = hi_n_q;
          lo_d    = lo_n_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    rdata     = rd_sel ? hi_q : lo_q;
    hilo_busy = start | busy_q;
    hi        = hi_q;
    lo        = lo_q;
  end

endmodule
